// File: rtl/seq_add_sub_if.sv
// Handshake and operand/result bundle for seq_add_sub.
// The requester takes the master modport, the arithmetic unit takes the slave modport.
interface seq_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry, overflow, zero
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry, overflow, zero
  );
endinterface

// File: rtl/seq_add_sub.sv
// Chunk-serial two's-complement adder/subtractor.
// It adds CHUNK bits per clock, least-significant chunk first, and takes N = WIDTH/CHUNK cycles.
//   state  | meaning
//   S_IDLE | waiting for start
//   S_RUN  | adding chunk k each cycle
//   S_DONE | one-cycle done pulse; a new start is accepted here
module seq_add_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst,
  seq_add_sub_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             cy;
  logic [CW-1:0]    k;
  logic [CHUNK:0]   chunk_sum;
  logic             last;

  always_comb begin
    chunk_sum = {1'b0, op_a[k*CHUNK +: CHUNK]} + {1'b0, op_b[k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, cy};
    acc_next  = acc;
    acc_next[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  assign last     = (k == CW'(N - 1));
  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      op_a         <= '0;
      op_b         <= '0;
      acc          <= '0;
      cy           <= 1'b0;
      k            <= '0;
      bus.result   <= '0;
      bus.carry    <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            // subtract is a + ~b + 1, so the +1 enters as the initial carry
            op_a  <= bus.a;
            op_b  <= bus.b ^ {WIDTH{bus.sub}};
            cy    <= bus.sub;
            k     <= '0;
            acc   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc <= acc_next;
          cy  <= chunk_sum[CHUNK];
          if (last) begin
            k            <= '0;
            state        <= S_DONE;
            bus.result   <= acc_next;
            bus.carry    <= chunk_sum[CHUNK];
            bus.overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                            (acc_next[WIDTH-1] != op_a[WIDTH-1]);
            bus.zero     <= (acc_next == '0);
          end else begin
            k <= k + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_add_sub.sv
// Randomized and directed checks of seq_add_sub against an arithmetic reference model.
// Three instances are used: 8/4 for the main tests, and 16/16 and 16/1 for the latency extremes.
module tb_seq_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_add_sub_if #(.WIDTH(8))  m8 ();
  seq_add_sub_if #(.WIDTH(16)) w16 ();
  seq_add_sub_if #(.WIDTH(16)) n16 ();

  seq_add_sub #(.WIDTH(8),  .CHUNK(4))  dut8  (.clk(clk), .rst(rst), .bus(m8.slave));
  seq_add_sub #(.WIDTH(16), .CHUNK(16)) dut16w (.clk(clk), .rst(rst), .bus(w16.slave));
  seq_add_sub #(.WIDTH(16), .CHUNK(1))  dut16n (.clk(clk), .rst(rst), .bus(n16.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int w, input longint x, input longint y, input bit s,
                                output longint r, output bit c, output bit v, output bit z);
    longint m, sx, sy, ss;
    m  = longint'(1) << w;
    r  = s ? x - y : x + y;
    r  = ((r % m) + m) % m;
    c  = s ? (x >= y) : (x + y >= m);
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    ss = s ? sx - sy : sx + sy;
    v  = (ss < -(m / 2)) || (ss >= m / 2);
    z  = (r == 0);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_excl8",  64'(m8.busy  & m8.done),  64'd0);
      chk("busy_done_excl16", 64'(n16.busy & n16.done), 64'd0);
    end
  end

  task automatic wait_done8(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!m8.done && lat < 40);
    if (!m8.done) chk("timeout8", 64'd0, 64'd1);
  endtask

  task automatic check8(input string tag, input longint x, input longint y, input bit s);
    longint r; bit c, v, z;
    model(8, x, y, s, r, c, v, z);
    chk({tag, "_result"},   64'(m8.result),   64'(r));
    chk({tag, "_carry"},    64'(m8.carry),    64'(c));
    chk({tag, "_overflow"}, 64'(m8.overflow), 64'(v));
    chk({tag, "_zero"},     64'(m8.zero),     64'(z));
  endtask

  // Called #1 after an edge with the unit idle or in its done cycle.
  task automatic run8(input string tag, input logic [7:0] x, input logic [7:0] y, input bit s);
    int lat;
    m8.a = x; m8.b = y; m8.sub = s; m8.start = 1'b1;
    @(posedge clk); #1;
    m8.start = 1'b0;
    m8.a = 8'($urandom); m8.b = 8'($urandom); m8.sub = 1'($urandom);
    wait_done8(lat);
    chk({tag, "_latency"}, 64'(lat), 64'd2);
    check8(tag, longint'(x), longint'(y), s);
  endtask

  task automatic run16(input string tag, input logic [15:0] x, input logic [15:0] y, input bit s);
    int lat_w, lat_n, cnt;
    longint r; bit c, v, z;
    w16.a = x; w16.b = y; w16.sub = s; w16.start = 1'b1;
    n16.a = x; n16.b = y; n16.sub = s; n16.start = 1'b1;
    @(posedge clk); #1;
    w16.start = 1'b0; n16.start = 1'b0;
    lat_w = -1; lat_n = -1; cnt = 0;
    while ((lat_w < 0 || lat_n < 0) && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      if (w16.done && lat_w < 0) lat_w = cnt;
      if (n16.done && lat_n < 0) lat_n = cnt;
    end
    model(16, longint'(x), longint'(y), s, r, c, v, z);
    chk({tag, "_lat_c16"}, 64'(lat_w), 64'd1);
    chk({tag, "_lat_c1"},  64'(lat_n), 64'd16);
    chk({tag, "_res_c16"}, 64'(w16.result), 64'(r));
    chk({tag, "_res_c1"},  64'(n16.result), 64'(r));
    chk({tag, "_cy_c16"},  64'(w16.carry),  64'(c));
    chk({tag, "_cy_c1"},   64'(n16.carry),  64'(c));
    chk({tag, "_ov_c16"},  64'(w16.overflow), 64'(v));
    chk({tag, "_ov_c1"},   64'(n16.overflow), 64'(v));
    chk({tag, "_z_c16"},   64'(w16.zero), 64'(z));
    chk({tag, "_z_c1"},    64'(n16.zero), 64'(z));
  endtask

  initial begin
    int lat, dones;
    m8.start = 0;  m8.sub = 0;  m8.a = 0;  m8.b = 0;
    w16.start = 0; w16.sub = 0; w16.a = 0; w16.b = 0;
    n16.start = 0; n16.sub = 0; n16.a = 0; n16.b = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   64'(m8.busy),     64'd0);
    chk("rst_done",   64'(m8.done),     64'd0);
    chk("rst_result", 64'(m8.result),   64'd0);
    chk("rst_carry",  64'(m8.carry),    64'd0);
    chk("rst_ovf",    64'(m8.overflow), 64'd0);
    chk("rst_zero",   64'(m8.zero),     64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run8("add_4_2",    8'd4,   8'd2,   1'b0);
    chk("add_4_2_exact", 64'(m8.result), 64'h06);
    run8("add_6_10",   8'd6,   8'd10,  1'b0);
    chk("add_6_10_exact", 64'(m8.result), 64'h10);
    run8("add_200_100", 8'd200, 8'd100, 1'b0);
    chk("add_200_100_exact", 64'({m8.carry, m8.result}), 64'h12C);
    run8("add_127_1",  8'd127, 8'd1,   1'b0);
    chk("add_127_1_ovf", 64'(m8.overflow), 64'd1);
    run8("sub_5_7",    8'd5,   8'd7,   1'b1);
    chk("sub_5_7_exact", 64'(m8.result), 64'hFE);
    run8("sub_0_0",    8'd0,   8'd0,   1'b1);
    chk("sub_0_0_zero", 64'(m8.zero), 64'd1);
    run8("sub_80_1",   8'h80,  8'd1,   1'b1);
    chk("sub_80_1_exact", 64'(m8.result), 64'h7F);
    @(posedge clk); #1;

    // start while busy must be ignored; then start again in the done cycle
    m8.a = 8'd3; m8.b = 8'd4; m8.sub = 1'b0; m8.start = 1'b1;
    @(posedge clk); #1;
    m8.a = 8'd9; m8.b = 8'd9; m8.sub = 1'b1;
    @(posedge clk); #1;
    m8.start = 1'b0;
    wait_done8(lat);
    chk("ignore_latency", 64'(lat + 1), 64'd2);
    chk("ignore_result",  64'(m8.result), 64'h07);
    m8.a = 8'd10; m8.b = 8'd20; m8.sub = 1'b0; m8.start = 1'b1;
    @(posedge clk); #1;
    m8.start = 1'b0;
    wait_done8(lat);
    chk("b2b_gap", 64'(lat + 1), 64'd3);
    check8("b2b", 64'd10, 64'd20, 1'b0);
    dones = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (m8.done) dones++;
    end
    chk("no_extra_done", 64'(dones), 64'd0);
    chk("result_holds",  64'(m8.result), 64'd30);

    // reset in the middle of RUN
    run8("pre_rst", 8'd250, 8'd9, 1'b0);
    m8.a = 8'd50; m8.b = 8'd60; m8.sub = 1'b0; m8.start = 1'b1;
    @(posedge clk); #1;
    m8.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy",   64'(m8.busy),     64'd0);
    chk("midrst_done",   64'(m8.done),     64'd0);
    chk("midrst_result", 64'(m8.result),   64'd0);
    chk("midrst_carry",  64'(m8.carry),    64'd0);
    chk("midrst_ovf",    64'(m8.overflow), 64'd0);
    chk("midrst_zero",   64'(m8.zero),     64'd0);
    dones = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (m8.done) dones++;
    end
    chk("midrst_no_done", 64'(dones), 64'd0);
    run8("post_rst", 8'd1, 8'd2, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run8("rnd8", 8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
      end
    end

    run16("ffff_p1", 16'hFFFF, 16'h0001, 1'b0);
    chk("ffff_p1_zero", 64'(n16.zero), 64'd1);
    run16("sub16_edge", 16'h8000, 16'h0001, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run16("rnd16", 16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
